// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel width, signed pixel type and signed max.
package cnn_pkg;
  localparam int PIXW = 8;

  typedef logic signed [PIXW-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for 2x2 pooling: one write or one combinational read per cycle.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 11,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);
  // No reset: every entry is written on an even row before the odd row reads it.
  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max pool over raster-order pixels.
// Define MAXPOOL_RELU_EN to clamp negative input pixels to 0 before pooling.
module maxpool2x2
  import cnn_pkg::*;
#(
  parameter int IMG_W = 22,
  parameter int IMG_H = 22,
  parameter int PIXW  = cnn_pkg::PIXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [PIXW-1:0] i_x,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [PIXW-1:0] o_y,
  output logic            o_last
);
  localparam int HW       = IMG_W / 2;
  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW       = (HW > 1) ? $clog2(HW) : 1;
  // An odd final row has no partner, so the last window ends one row earlier.
  localparam int LAST_ROW = (IMG_H % 2 == 0) ? IMG_H - 1 : IMG_H - 2;

  if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 2) begin : g_bad_geom
    $error("maxpool2x2: IMG_W must be even and >=2, IMG_H must be >=2");
  end
  if (PIXW != cnn_pkg::PIXW) begin : g_bad_pixw
    $error("maxpool2x2: PIXW must match cnn_pkg::PIXW");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          px, pair_q, buf_rd, buf_wd, y_q;
  logic          acc, col_end, row_end, buf_we, win_done;
  logic [AW-1:0] buf_addr;

  assign i_ready = !o_valid || o_ready;
  assign acc     = i_valid && i_ready;

`ifdef MAXPOOL_RELU_EN
  assign px = i_x[PIXW-1] ? '0 : pix_t'(i_x);
`else
  assign px = pix_t'(i_x);
`endif

  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign buf_we   = acc && !row[0] && col[0];
  assign win_done = acc && row[0] && col[0];
  assign buf_addr = AW'(col >> 1);
  assign buf_wd   = smax(pair_q, px);

  pool_line_buf #(.DEPTH(HW)) u_lbuf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (buf_wd),
    .rdata (buf_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      pair_q  <= '0;
      y_q     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
        // Even column: left pixel of the pair, on either row of the window.
        if (!col[0]) pair_q <= px;
      end
      if (win_done) begin
        y_q     <= smax(smax(buf_rd, pair_q), px);
        o_valid <= 1'b1;
        o_last  <= (row == RW'(LAST_ROW)) && col_end;
      end else if (o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

  assign o_y = y_q;
endmodule

// File: tb/tb_maxpool2x2.sv
// Scoreboard bench for maxpool2x2: a 4x4 instance and a 4x5 (odd height) instance.
module tb_maxpool2x2;
  logic       clk = 1'b0;
  logic       reset;
  logic       iv[2], ir[2], ov[2], ordy[2], last[2];
  logic [7:0] x[2], y[2];

  always #5 clk = ~clk;

  maxpool2x2 #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .reset(reset), .i_valid(iv[0]), .i_ready(ir[0]), .i_x(x[0]),
    .o_valid(ov[0]), .o_ready(ordy[0]), .o_y(y[0]), .o_last(last[0]));

  maxpool2x2 #(.IMG_W(4), .IMG_H(5)) dut_b (
    .clk(clk), .reset(reset), .i_valid(iv[1]), .i_ready(ir[1]), .i_x(x[1]),
    .o_valid(ov[1]), .o_ready(ordy[1]), .o_y(y[1]), .o_last(last[1]));

  typedef struct {int v; bit l;} res_t;
  res_t exp_q[$], got_q[$];
  int   errors = 0, checks = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (!reset && ov[d] && ordy[d]) got_q.push_back('{v: int'($signed(y[d])), l: last[d]});
  end

  // Reference: independent window maxima over one frame of w x h pixels.
  task automatic model(input int w, input int h, input int px[$]);
    for (int r2 = 0; r2 < h / 2; r2++)
      for (int c2 = 0; c2 < w / 2; c2++) begin
        int m = -1000;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            int v = px[(2 * r2 + dr) * w + 2 * c2 + dc];
`ifdef MAXPOOL_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > m) m = v;
          end
        exp_q.push_back('{v: m, l: (r2 == h / 2 - 1) && (c2 == w / 2 - 1)});
      end
  endtask

  task automatic drive(input int d, input int px[$], input int gap_pct);
    foreach (px[i]) begin
      bit acc;
      int n;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        iv[d] = 1'b0;
        @(posedge clk); #1;
      end
      iv[d] = 1'b1;
      x[d]  = 8'(px[i]);
      acc = 1'b0;
      n   = 0;
      do begin
        @(negedge clk); acc = ir[d];
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 100);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_timeout dut=%0d pixel=%0d: i_ready stayed 0, required 1", d, i);
      end
    end
    iv[d] = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 60) begin
      @(posedge clk); n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", ov[0]); end
    checks++; if (last[0] !== 1'b0) begin errors++; $display("FAIL reset_o_last got=%b exp=0", last[0]); end
    checks++; if (y[0] !== 8'd0) begin errors++; $display("FAIL reset_o_y got=%0d exp=0", y[0]); end
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL reset_i_ready got=%b exp=1", ir[0]); end
    checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL reset_b_o_valid got=%b exp=0", ov[1]); end
  endtask

  task automatic test_basic();
    int px[$];
    int want[4] = '{5, 7, 13, 15};
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) px.push_back(i);
    for (int i = 0; i < 4; i++) exp_q.push_back('{v: want[i], l: (i == 3)});
    drive(0, px, 0);
    wait_out();
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].v !== want[i] || got_q[i].l !== (i == 3)) begin
        errors++;
        $display("FAIL basic_out[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_q[i].v, got_q[i].l, want[i], i == 3);
      end
    end
  endtask

  task automatic test_stall();
    int px[$];
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) px.push_back(i);
    model(4, 4, px);
    fork
      drive(0, px, 0);
      begin
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!(ov[0] && $signed(y[0]) == 7) && n < 200);
        if (n >= 200) begin
          checks++; errors++;
          $display("FAIL stall_detect: o_y=7 never presented");
        end else begin
          ordy[0] = 1'b0;
          repeat (3) begin
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1 || $signed(y[0]) !== 7 || ir[0] !== 1'b0) begin
              errors++;
              $display("FAIL stall_hold got v=%b y=%0d ir=%b exp v=1 y=7 ir=0", ov[0], $signed(y[0]), ir[0]);
            end
            @(posedge clk); #1;
          end
          ordy[0] = 1'b1;
        end
      end
    join
    wait_out();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].l !== exp_q[i].l) begin
        errors++;
        $display("FAIL stall_out[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i].v, got_q[i].l, exp_q[i].v, exp_q[i].l);
      end
    end
  endtask

  task automatic test_relu_window();
    int px[$] = '{-5, -3, 10, 11, -8, -2, 12, 13, 1, 2, 3, 4, 5, 6, 7, 8};
    int first;
`ifdef MAXPOOL_RELU_EN
    first = 0;
`else
    first = -2;
`endif
    got_q.delete(); exp_q.delete();
    model(4, 4, px);
    drive(0, px, 0);
    wait_out();
    checks++;
    if (got_q.size() < 1 || got_q[0].v !== first) begin
      errors++;
      $display("FAIL neg_window got=%0d exp=%0d", (got_q.size() > 0) ? got_q[0].v : 9999, first);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL neg_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 1; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].l !== exp_q[i].l) begin
        errors++;
        $display("FAIL neg_out[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i].v, got_q[i].l, exp_q[i].v, exp_q[i].l);
      end
    end
  endtask

  task automatic test_odd_height();
    int f1[$], f2[$], all[$];
    int nlast = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) f1.push_back(i);
    for (int i = 0; i < 20; i++) f2.push_back(50 - 3 * i);
    model(4, 5, f1);
    model(4, 5, f2);
    all = {f1, f2};
    drive(1, all, 0);
    wait_out();
    checks++;
    if (got_q.size() !== 8) begin errors++; $display("FAIL oddh_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].l !== exp_q[i].l) begin
        errors++;
        $display("FAIL oddh_out[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i].v, got_q[i].l, exp_q[i].v, exp_q[i].l);
      end
      if (got_q[i].l) nlast++;
    end
    checks++;
    if (nlast !== 2) begin errors++; $display("FAIL oddh_lasts got=%0d exp=2", nlast); end
  endtask

  task automatic test_reset_mid();
    int part[$], px[$];
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) part.push_back(100 + i);
    for (int i = 0; i < 16; i++) px.push_back(i);
    ordy[0] = 1'b0;
    drive(0, part, 0);
    pulse_reset();
    checks++;
    if (ov[0] !== 1'b0 || last[0] !== 1'b0 || y[0] !== 8'd0) begin
      errors++;
      $display("FAIL midreset_clear got v=%b l=%b y=%0d exp 0/0/0", ov[0], last[0], y[0]);
    end
    ordy[0] = 1'b1;
    model(4, 4, px);
    drive(0, px, 0);
    wait_out();
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL midreset_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].l !== exp_q[i].l) begin
        errors++;
        $display("FAIL midreset_out[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i].v, got_q[i].l, exp_q[i].v, exp_q[i].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f1[$], f2[$], all[$];
    int nlast = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) f1.push_back(int'($urandom_range(255)) - 128);
    for (int i = 0; i < 16; i++) f2.push_back(int'($urandom_range(255)) - 128);
    model(4, 4, f1);
    model(4, 4, f2);
    all = {f1, f2};
    drive(0, all, 30);
    wait_out();
    checks++;
    if (got_q.size() !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].l !== exp_q[i].l) begin
        errors++;
        $display("FAIL b2b_out[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i].v, got_q[i].l, exp_q[i].v, exp_q[i].l);
      end
      if (got_q[i].l) nlast++;
    end
    checks++;
    if (nlast !== 2) begin errors++; $display("FAIL b2b_lasts got=%0d exp=2", nlast); end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; x[d] = 8'd0; ordy[d] = 1'b1;
    end
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_stall();
    test_relu_window();
    test_odd_height();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxpool2x2.md
MAXPOOL2X2 -- requirements
Module: maxpool2x2

Interface
REQ-001 SHALL have parameter IMG_W, default 22: pixels per input row (conv output width); even, >=2.
REQ-002 SHALL have parameter IMG_H, default 22: rows per input frame; >=2.
REQ-003 SHALL have parameter PIXW, default 8: pixel width, signed two's complement.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_valid  in  1  upstream pixel valid.
REQ-007 SHALL have port i_ready  out  1  block accepts i_x this cycle.
REQ-008 SHALL have port i_x  in  PIXW  input pixel, raster order.
REQ-009 SHALL have port o_valid  out  1  pooled pixel valid.
REQ-010 SHALL have port o_ready  in  1  downstream accepts o_y.
REQ-011 SHALL have port o_y  out  PIXW  pooled pixel.
REQ-012 SHALL have port o_last  out  1  o_y is the final pooled pixel of the frame.

Function
REQ-013 SHALL pool 2x2 windows at stride 2, producing one output per window: (IMG_W/2) x (IMG_H/2) outputs per frame.
REQ-014 SHALL accept a pixel only on cycles with i_valid && i_ready; i_ready = !o_valid || o_ready (combinational).
REQ-015 SHALL compare signed; output = max of the 4 window pixels.
REQ-016 SHALL track column counter 0..IMG_W-1 and row counter 0..IMG_H-1; both wrap to 0 after the last pixel of the frame.
REQ-017 Even row, odd column: SHALL write max(previous pixel, current pixel) into line-buffer entry col/2.
REQ-018 Odd row, even column: SHALL hold the pixel in a pair register.
REQ-019 Odd row, odd column: SHALL load o_y with max(buffer[col/2], pair reg, i_x) and set o_valid next cycle (latency 1 cycle from accepting the window's last pixel).
REQ-020 SHALL keep o_y, o_valid, o_last stable while o_valid && !o_ready; SHALL clear o_valid after a handshake unless a new result loads in the same cycle.
REQ-021 Odd IMG_H: the final unpaired row SHALL be consumed and discarded, with no output.
REQ-022 o_last SHALL be 1 only with the output from row IMG_H-1 (or IMG_H-2 if IMG_H odd) and column IMG_W-1.
REQ-023 Sustained throughput SHALL be 1 input per cycle while o_ready stays high.
REQ-024 Illegal IMG_W (odd or <2) or IMG_H <2 SHALL cause an elaboration-time error.

Reset
REQ-025 While reset is high at a clock edge, o_valid, o_last, o_y, the counters and the pair register SHALL become 0.
REQ-026 Line-buffer contents SHALL NOT be reset; each entry is always written before it is read.
REQ-027 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is row 0, column 0.

Configuration
REQ-028 With MAXPOOL_RELU_EN defined, each accepted pixel SHALL be clamped to 0 if negative before any compare, so o_y >= 0.
REQ-029 Without MAXPOOL_RELU_EN, raw signed values SHALL be pooled and negative outputs are possible.

Structure
REQ-030 cnn_pkg SHALL hold PIXW, typedef pix_t (signed [PIXW-1:0]) and the function smax(a,b).
REQ-031 The line buffer SHALL be a sub-module pool_line_buf: IMG_W/2 x PIXW, single port, 1 write or 1 combinational read per cycle.

Verification
REQ-032 IMG_W=4, IMG_H=4, input 0..15, o_ready=1 -> outputs 5,7,13,15; o_last only with 15.
REQ-033 Same stimulus, o_ready low for 3 cycles when o_y=7 is presented -> 7 held stable, i_ready=0 during the stall, no input loss, same output sequence.
REQ-034 Window {-5,-3,-8,-2}: without the macro -> -2; with MAXPOOL_RELU_EN -> 0.
REQ-035 IMG_H=5, IMG_W=4, input 0..19 -> exactly 4 outputs (5,7,13,15); o_last with 15; row 4 discarded; next frame starts cleanly.
REQ-036 Reset asserted after 6 pixels, then full frame 0..15 -> no output from the partial frame, outputs 5,7,13,15.
REQ-037 Two back-to-back frames with random i_valid gaps -> results match the reference model; o_last once per frame.
